// File: rtl/dbg_bridge_pkg.sv
// rtl/dbg_bridge_pkg.sv - shared types and constants for the debug memory bridge
package dbg_bridge_pkg;

    // Command register is sized for the widest supported bus; narrower instances leave the top bits zero.
    localparam int unsigned CMD_ADDR_W = 64;
    localparam int unsigned CMD_DATA_W = 64;

    localparam logic [CMD_DATA_W/8-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dbg_br_state_e;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } dbg_cmd_t;

    function automatic int TIMEOUT_W(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dbg_mem_bridge_if.sv
// rtl/dbg_mem_bridge_if.sv - req/gnt/rvalid system-bus port of the debug memory bridge
interface dbg_mem_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                bus_req_o;
    logic                bus_gnt_i;
    logic                bus_we_o;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic [DATA_W-1:0]   bus_wdata_o;
    logic [DATA_W/8-1:0] bus_be_o;
    logic                bus_rvalid_i;
    logic [DATA_W-1:0]   bus_rdata_i;
    logic                bus_err_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );
endinterface

// File: rtl/dbg_timeout_cnt.sv
// rtl/dbg_timeout_cnt.sv - saturating access timer with clear, enable and hit
module dbg_timeout_cnt
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int W = TIMEOUT_W(LIMIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != W'(LIMIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the edge that completes the LIMIT-th counted cycle.
    assign hit = en && (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/dbg_mem_bridge.sv
// rtl/dbg_mem_bridge.sv - debug-module level command to req/gnt/rvalid bus bridge
module dbg_mem_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dbg_op_req_i,
    input  logic              dbg_mem_we_i,
    input  logic [ADDR_W-1:0] dbg_mem_addr_i,
    input  logic [DATA_W-1:0] dbg_mem_wdata_i,
    output logic [DATA_W-1:0] dbg_mem_rdata_o,
    output logic              dbg_busy_o,
    output logic              dbg_err_o,
    dbg_mem_bridge_if.master  bus
);
    dbg_br_state_e state_q, state_d;
    dbg_cmd_t      cmd_q, live_cmd;

    logic accept;
    logic misaligned;
    logic set_err;
    logic load_rdata;
    logic tmo_hit;
    logic tmo_en;

    always_comb begin
        live_cmd                    = '0;
        live_cmd.we                 = dbg_mem_we_i;
        live_cmd.addr[ADDR_W-1:0]   = dbg_mem_addr_i;
        live_cmd.wdata[DATA_W-1:0]  = dbg_mem_wdata_i;
    end

    assign misaligned = |dbg_mem_addr_i[1:0];
    assign tmo_en     = (state_q == REQ) || (state_q == RESP);

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        set_err    = 1'b0;
        load_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg_op_req_i) accept = 1'b1;
            end
            REQ: begin
                // Timeout wins over a coincident grant; any late response is then stray.
                if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else if (bus.bus_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.bus_rvalid_i) begin
                    set_err    = bus.bus_err_i;
                    load_rdata = !cmd_q.we && !bus.bus_err_i;
                    state_d    = DONE;
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!dbg_op_req_i) state_d = IDLE;
                else if (live_cmd != cmd_q) accept = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) state_d = misaligned ? DONE : REQ;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cmd_q           <= '0;
            dbg_mem_rdata_o <= '0;
            dbg_err_o       <= 1'b0;
            dbg_busy_o      <= 1'b0;
            bus.bus_req_o   <= 1'b0;
            bus.bus_be_o    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) cmd_q <= live_cmd;
            if (accept)       dbg_err_o <= misaligned;
            else if (set_err) dbg_err_o <= 1'b1;
            if (load_rdata) dbg_mem_rdata_o <= bus.bus_rdata_i;
            dbg_busy_o    <= (state_d == REQ) || (state_d == RESP);
            bus.bus_req_o <= (state_d == REQ);
            bus.bus_be_o  <= (state_d == REQ) ? BE_ALL[DATA_W/8-1:0] : '0;
        end
    end

    assign bus.bus_we_o    = cmd_q.we;
    assign bus.bus_addr_o  = cmd_q.addr[ADDR_W-1:0];
    assign bus.bus_wdata_o = cmd_q.wdata[DATA_W-1:0];

    dbg_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (accept),
        .en    (tmo_en),
        .hit   (tmo_hit)
    );

endmodule
